pipe_skid_latch: RTL and testbench
==================================

PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 Parameter DATA_W, default 96, payload width in bits.
REQ-002 Parameter CNT_W, default 16, width of both statistics counters.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rsn_i  input  1  reset, asynchronous, active-low.
REQ-005 kill_i  input  1  synchronous flush of all held entries.
REQ-006 up_valid_i  input  1  upstream entry valid.
REQ-007 up_data_i  input  DATA_W  upstream payload.
REQ-008 up_ready_o  output  1  latch can accept an entry this cycle.
REQ-009 dn_valid_o  output  1  downstream entry valid.
REQ-010 dn_data_o  output  DATA_W  downstream payload.
REQ-011 dn_ready_i  input  1  downstream consumes the entry this cycle; replaces the stall_core_i style stall.
REQ-012 occ_o  output  2  number of held entries, 0..2.
REQ-013 stall_cnt_o  output  CNT_W  cycles with dn_valid_o=1 and dn_ready_i=0.
REQ-014 drop_cnt_o  output  CNT_W  entries discarded by kill_i.

Function
REQ-015 Storage: main register (drives dn_data_o) plus one skid register; state EMPTY, ONE or TWO.
REQ-016 push = up_valid_i & up_ready_o; pop = dn_valid_o & dn_ready_i.
REQ-017 up_ready_o = (state != TWO), decoded from the state register only; no combinational path from dn_ready_i or up_valid_i.
REQ-018 dn_valid_o = (state != EMPTY); dn_data_o = main register; occ_o = 0/1/2 for EMPTY/ONE/TWO.
REQ-019 EMPTY: push -> ONE, main <= up_data_i; otherwise stay.
REQ-020 ONE: push & pop -> ONE, main <= up_data_i; push only -> TWO, skid <= up_data_i; pop only -> EMPTY; neither -> stay.
REQ-021 TWO: pop -> ONE, main <= skid; no pop -> stay, main and skid unchanged.
REQ-022 Latency: an entry pushed into EMPTY, or into ONE with a simultaneous pop, appears on dn_data_o the next cycle.
REQ-023 Ordering is strictly FIFO; no entry is duplicated or lost except by kill_i.
REQ-024 kill_i = 1: next state EMPTY, main and skid <= 0; takes priority over push and pop in the same cycle; the upstream entry offered that cycle is discarded.
REQ-025 On kill_i, drop_cnt_o += occ_o and saturates at all-ones; a pop in the kill cycle is still counted as dropped.
REQ-026 stall_cnt_o increments by 1 each cycle with dn_valid_o=1 and dn_ready_i=0, including a kill cycle; saturates at all-ones.
REQ-027 kill_i does not clear stall_cnt_o or drop_cnt_o.
REQ-028 Data registers hold their value when not loaded; no X propagation when up_valid_i=0.

Reset
REQ-029 rsn_i = 0 asynchronously forces state EMPTY, main = 0, skid = 0, stall_cnt_o = 0, drop_cnt_o = 0.
REQ-030 During reset: up_ready_o = 1, dn_valid_o = 0, occ_o = 0, dn_data_o = 0.
REQ-031 Reset asserted mid-transfer discards held entries without counting them in drop_cnt_o.
REQ-032 The first push is accepted on the first rising edge after rsn_i deasserts.

Structure
REQ-033 The shared pipeline package holds the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and default-width constants.
REQ-034 The statistics counters are instances of one sub-module, sat_counter, with parameters WIDTH and increment width, and inputs inc_en and inc_val.
REQ-035 Existing fixed-field stage latches are replaced by this block, with fields concatenated into up_data_i.

Verification
REQ-036 Push A=0x1, B=0x2, C=0x3 on consecutive cycles with dn_ready_i=0 -> occ_o 1,2,2; up_ready_o=0 after B; C not accepted; stall_cnt_o counts each held cycle.
REQ-037 From TWO holding A,B, raise dn_ready_i for 2 cycles -> dn_data_o A then B, occ_o 1 then 0, up_ready_o=1 after the first pop.
REQ-038 Continuous push with dn_ready_i=1 for 100 cycles -> throughput 1/cycle, occ_o stays 1, latency 1.
REQ-039 TWO state, kill_i=1 with up_valid_i=1 -> next cycle occ_o=0, dn_data_o=0, drop_cnt_o += 2, pushed entry absent.
REQ-040 CNT_W=4, hold dn_valid_o=1 and dn_ready_i=0 for 20 cycles -> stall_cnt_o saturates at 15.
REQ-041 Assert rsn_i=0 asynchronously between edges while in ONE -> outputs at reset values immediately, drop_cnt_o unchanged at 0.

Source files
------------

// File: rtl/pipe_skid_latch_pkg.sv
// Shared pipeline package for the skid latch.
// Holds the occupancy state encoding, the default widths and a helper
// function that maps a state to its entry count.
package pipe_skid_latch_pkg;

  localparam int DEFAULT_DATA_W = 96;
  localparam int DEFAULT_CNT_W  = 16;

  // EMPTY: nothing held, ONE: main register valid, TWO: main and skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Number of held entries for a given state.
  function automatic logic [1:0] occ_of(input state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage : pipe_skid_latch_pkg

// File: rtl/pipe_skid_latch_sat_counter.sv
// Saturating statistics counter.
// Adds inc_val to the count whenever inc_en is high and clamps at
// all-ones instead of wrapping.
//   clk_i    : clock
//   rsn_i    : asynchronous active-low reset, clears the count
//   inc_en   : add inc_val this cycle
//   inc_val  : increment amount, INC_W bits (INC_W <= WIDTH)
//   cnt_o    : current count
module sat_counter #(
  parameter int WIDTH = 16,
  parameter int INC_W = 1
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             inc_en,
  input  logic [INC_W-1:0] inc_val,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    // One extra bit catches the carry out; a carry means the sum passed
    // the all-ones ceiling.
    sum   = {1'b0, cnt_q} + {{(WIDTH + 1 - INC_W){1'b0}}, inc_val};
    cnt_d = cnt_q;
    if (inc_en) begin
      cnt_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/pipe_skid_latch.sv
// Two-entry valid/ready pipeline latch with a skid register.
// The main register drives the downstream payload; the skid register
// catches the one entry that may arrive while downstream stalls, so
// up_ready_o can be a pure register decode.
//   clk_i        : clock
//   rsn_i        : asynchronous active-low reset
//   kill_i       : synchronous flush of all held entries
//   up_valid_i   : upstream entry valid
//   up_data_i    : upstream payload
//   up_ready_o   : latch can accept an entry this cycle
//   dn_valid_o   : downstream entry valid
//   dn_data_o    : downstream payload (main register)
//   dn_ready_i   : downstream consumes the entry this cycle
//   occ_o        : number of held entries, 0..2
//   stall_cnt_o  : cycles with dn_valid_o=1 and dn_ready_i=0 (saturating)
//   drop_cnt_o   : entries discarded by kill_i (saturating)
module pipe_skid_latch
  import pipe_skid_latch_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              kill_i,
  input  logic              up_valid_i,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              up_ready_o,
  output logic              dn_valid_o,
  output logic [DATA_W-1:0] dn_data_o,
  input  logic              dn_ready_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              push;
  logic              pop;

  // Handshake outputs come from the state register only, which breaks any
  // combinational ready path between upstream and downstream.
  assign up_ready_o = (state_q != TWO);
  assign dn_valid_o = (state_q != EMPTY);
  assign dn_data_o  = main_q;
  assign occ_o      = occ_of(state_q);

  assign push = up_valid_i & up_ready_o;
  assign pop  = dn_valid_o & dn_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (kill_i) begin
      // Flush wins over any push or pop in the same cycle.
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = up_data_i;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b11: main_d = up_data_i;
            2'b10: begin
              state_d = TWO;
              skid_d  = up_data_i;
            end
            2'b01: state_d = EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          // up_ready_o is low here, so only a pop can move the state.
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // A kill cycle still counts as a stall when downstream is not ready.
  sat_counter #(
    .WIDTH (CNT_W),
    .INC_W (1)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .inc_en  (dn_valid_o & ~dn_ready_i),
    .inc_val (1'b1),
    .cnt_o   (stall_cnt_o)
  );

  // Every entry held at kill time is dropped, including one being popped.
  sat_counter #(
    .WIDTH (CNT_W),
    .INC_W (2)
  ) u_drop_cnt (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .inc_en  (kill_i),
    .inc_val (occ_o),
    .cnt_o   (drop_cnt_o)
  );

endmodule : pipe_skid_latch

// File: tb/tb_pipe_skid_latch.sv
// Self-checking bench for pipe_skid_latch: a reference queue of accepted
// entries is compared against every downstream pop, and occupancy,
// handshake and counters are compared against a small behavioural model.
module tb_pipe_skid_latch;

  localparam int DW  = 96;
  localparam int CW  = 16;
  localparam int SDW = 8;
  localparam int SCW = 4;

  logic          clk;
  logic          rsn;
  logic          kill;
  logic          up_valid;
  logic [DW-1:0] up_data;
  logic          up_ready;
  logic          dn_valid;
  logic [DW-1:0] dn_data;
  logic          dn_ready;
  logic [1:0]    occ;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] drop_cnt;

  // Narrow-counter instance for saturation checks.
  logic           s_kill;
  logic           s_valid;
  logic [SDW-1:0] s_data;
  logic           s_up_ready;
  logic           s_dn_valid;
  logic [SDW-1:0] s_dn_data;
  logic           s_ready;
  logic [1:0]     s_occ;
  logic [SCW-1:0] s_stall;
  logic [SCW-1:0] s_drop;

  int tests;
  int fails;

  logic [DW-1:0] sb[$];
  int m_occ;
  int m_stall;
  int m_drop;

  pipe_skid_latch #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i       (clk),
    .rsn_i       (rsn),
    .kill_i      (kill),
    .up_valid_i  (up_valid),
    .up_data_i   (up_data),
    .up_ready_o  (up_ready),
    .dn_valid_o  (dn_valid),
    .dn_data_o   (dn_data),
    .dn_ready_i  (dn_ready),
    .occ_o       (occ),
    .stall_cnt_o (stall_cnt),
    .drop_cnt_o  (drop_cnt)
  );

  pipe_skid_latch #(.DATA_W(SDW), .CNT_W(SCW)) dut_small (
    .clk_i       (clk),
    .rsn_i       (rsn),
    .kill_i      (s_kill),
    .up_valid_i  (s_valid),
    .up_data_i   (s_data),
    .up_ready_o  (s_up_ready),
    .dn_valid_o  (s_dn_valid),
    .dn_data_o   (s_dn_data),
    .dn_ready_i  (s_ready),
    .occ_o       (s_occ),
    .stall_cnt_o (s_stall),
    .drop_cnt_o  (s_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus, entered and left just after a falling edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic k);
    logic [DW-1:0] exp_d;
    up_valid = v;
    up_data  = d;
    dn_ready = r;
    kill     = k;
    #1;
    tests++;
    if (occ !== 2'(m_occ)) begin
      fails++;
      $display("FAIL occ: got %0d expected %0d", occ, m_occ);
    end
    tests++;
    if (up_ready !== (m_occ != 2)) begin
      fails++;
      $display("FAIL up_ready: got %b expected %b", up_ready, (m_occ != 2));
    end
    tests++;
    if (dn_valid !== (m_occ != 0)) begin
      fails++;
      $display("FAIL dn_valid: got %b expected %b", dn_valid, (m_occ != 0));
    end
    tests++;
    if (stall_cnt !== CW'(m_stall)) begin
      fails++;
      $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, m_stall);
    end
    tests++;
    if (drop_cnt !== CW'(m_drop)) begin
      fails++;
      $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt, m_drop);
    end
    if (!k && m_occ > 0 && r) begin
      exp_d = sb.pop_front();
      tests++;
      if (dn_data !== exp_d) begin
        fails++;
        $display("FAIL pop_data: got %h expected %h", dn_data, exp_d);
      end
    end
    if (m_occ > 0 && !r && m_stall < 65535) m_stall++;
    if (k) begin
      m_drop = (m_drop + m_occ > 65535) ? 65535 : m_drop + m_occ;
      sb.delete();
    end else if (v && m_occ < 2) begin
      sb.push_back(d);
    end
    m_occ = sb.size();
    $display("[TB] step v=%b d=%h r=%b k=%b -> occ=%0d", v, d, r, k, m_occ);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({up_ready, dn_valid, occ} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_hs: got ready=%b valid=%b occ=%0d expected 1 0 0", up_ready, dn_valid, occ);
    end
    tests++;
    if (dn_data !== '0 || stall_cnt !== '0 || drop_cnt !== '0) begin
      fails++;
      $display("FAIL reset_regs: got data=%h stall=%0d drop=%0d expected 0", dn_data, stall_cnt, drop_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rsn = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_fill();
    step(1'b1, DW'(1), 1'b0, 1'b0);
    step(1'b1, DW'(2), 1'b0, 1'b0);
    step(1'b1, DW'(3), 1'b0, 1'b0);  // refused: latch full
    tests++;
    if (dn_data !== DW'(1)) begin
      fails++;
      $display("FAIL fill_head: got %h expected %h", dn_data, DW'(1));
    end
  endtask

  task automatic test_drain();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 100; i++) begin
      step(1'b1, {$urandom, $urandom, $urandom}, 1'b1, 1'b0);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    step(1'b1, DW'(8'h55), 1'b0, 1'b0);
    #2;
    rsn = 1'b0;
    #1;
    tests++;
    if ({up_ready, dn_valid, occ} !== 4'b1000 || dn_data !== '0) begin
      fails++;
      $display("FAIL async_reset_out: got ready=%b valid=%b occ=%0d data=%h", up_ready, dn_valid, occ, dn_data);
    end
    tests++;
    if (drop_cnt !== '0 || stall_cnt !== '0) begin
      fails++;
      $display("FAIL async_reset_cnt: got drop=%0d stall=%0d expected 0 0", drop_cnt, stall_cnt);
    end
    $display("[TB] async reset asserted mid-cycle");
    sb.delete();
    m_occ   = 0;
    m_stall = 0;
    m_drop  = 0;
    @(negedge clk);
    rsn = 1'b1;
    step(1'b1, DW'(8'h77), 1'b0, 1'b0);  // first edge after release
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_kill();
    step(1'b1, DW'(8'hA1), 1'b0, 1'b0);
    step(1'b1, DW'(8'hB2), 1'b0, 1'b0);
    step(1'b1, DW'(16'hDEAD), 1'b1, 1'b1);
    tests++;
    if (dn_data !== '0) begin
      fails++;
      $display("FAIL kill_data: got %h expected 0", dn_data);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_stall_sat();
    int exp_s;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    s_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_s = (i > 15) ? 15 : i;
      tests++;
      if (s_stall !== SCW'(exp_s)) begin
        fails++;
        $display("FAIL stall_sat: cycle %0d got %0d expected %0d", i, s_stall, exp_s);
      end
      $display("[TB] small stall cycle %0d cnt=%0d", i, s_stall);
    end
    tests++;
    if (s_occ !== 2'd1 || s_dn_data !== 8'hA5) begin
      fails++;
      $display("FAIL small_hold: got occ=%0d data=%h expected 1 a5", s_occ, s_dn_data);
    end
    s_kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_kill = 1'b0;
    tests++;
    if (s_drop !== 4'd1 || s_occ !== 2'd0 || s_stall !== 4'd15) begin
      fails++;
      $display("FAIL small_kill: got drop=%0d occ=%0d stall=%0d expected 1 0 15", s_drop, s_occ, s_stall);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    m_occ    = 0;
    m_stall  = 0;
    m_drop   = 0;
    rsn      = 1'b0;
    kill     = 1'b0;
    up_valid = 1'b0;
    up_data  = '0;
    dn_ready = 1'b0;
    s_kill   = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_ready  = 1'b1;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_async_reset();
    test_kill();
    test_stall_sat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pipe_skid_latch
